adc_lane_serializer: RTL and testbench

ADC_LANE_SERIALIZER -- requirements
Module: adc_lane_serializer

---
 rtl/adc_if_pkg.sv | 30 +++
 rtl/adc_lane_shift.sv | 46 ++++
 rtl/adc_lane_serializer.sv | 177 +++++++++++++++++
 tb/tb_adc_lane_serializer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_if_pkg.sv
// Shared definitions for the ADC lane serializer.
// Holds the test-pattern source encodings, the serializer states and the
// fixed pattern words used by the ramp/checkerboard/midscale generators.
package adc_if_pkg;

    localparam int unsigned RAMP_W = 14;

    // Source select on the mode input
    typedef enum logic [1:0] {
        MODE_DIN      = 2'd0,
        MODE_RAMP     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_MIDSCALE = 2'd3
    } adc_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ser_state_e;

    localparam logic [RAMP_W-1:0] CHECKER_A      = 14'h2AAA;
    localparam logic [RAMP_W-1:0] CHECKER_B      = 14'h1555;
    localparam logic [RAMP_W-1:0] FIXED_MIDSCALE = 14'h2000;

    // Midscale code for a given sample width (MSB set, rest clear)
    function automatic logic [15:0] midscale(input int unsigned width);
        return 16'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/adc_lane_shift.sv
// One serial lane: WIDTH-bit register that parallel-loads a word and then
// shifts left two bits per clock, presenting its top two bits as a DDR pair.
//   clk, rst_n : clock, async active-low reset
//   load_i     : load word_i (takes priority over shift_i)
//   shift_i    : shift left by two, zero fill
//   word_i     : parallel word to load
//   q1_o/q2_o  : rising-edge / falling-edge bit of the current pair
module adc_lane_shift
    import adc_if_pkg::*;
#(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] word_i,
    output logic             q1_o,
    output logic             q2_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load / shift-by-two next state
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = word_i;
        end else if (shift_i) begin
            sr_d = {sr_q[WIDTH-3:0], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q1_o = sr_q[WIDTH-1];
    assign q2_o = sr_q[WIDTH-2];

endmodule

// File: rtl/adc_lane_serializer.sv
// LVDS-style ADC output serializer: LANES data lanes, WIDTH bits per sample,
// two bits per dco cycle (MSB first) plus a frame clock bit pair.
//   dco, rst_n        : bit clock, async active-low reset
//   en                : run request, honoured only at frame boundaries
//   mode              : source select (din, ramp, checkerboard, midscale)
//   inv_mask          : per-lane inversion, sampled at the boundary
//   din/din_valid     : parallel samples, accepted when din_ready is high
//   din_ready         : boundary & en & din mode
//   dq1/dq2           : per-lane DDR bit pair
//   fco_q1/fco_q2     : frame clock bit pair
//   frame_start       : high while the MSB pair is on dq
//   underflow_cnt     : frames sent with no din available (saturating)
// RAMP_INIT sets the reset value of the ramp generator (0 in normal use).
module adc_lane_serializer
    import adc_if_pkg::*;
#(
    parameter int unsigned       LANES     = 8,
    parameter int unsigned       WIDTH     = 14,
    parameter logic [RAMP_W-1:0] RAMP_INIT = '0
) (
    input  logic                   dco,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [LANES-1:0]       inv_mask,
    input  logic [LANES*WIDTH-1:0] din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [LANES-1:0]       dq1,
    output logic [LANES-1:0]       dq2,
    output logic                   fco_q1,
    output logic                   fco_q2,
    output logic                   frame_start,
    output logic [15:0]            underflow_cnt
);

    localparam int unsigned       HALF     = WIDTH / 2;
    localparam int unsigned       PW       = $clog2(HALF);
    localparam logic [PW-1:0]     P_LAST   = PW'(HALF - 1);
    localparam logic [PW-1:0]     P_FCO    = PW'(WIDTH / 4);
    localparam bit                FCO_MID  = (HALF % 2) == 1;
    localparam logic [WIDTH-1:0]  MIDSCALE = WIDTH'(midscale(WIDTH));

    ser_state_e        state_q, state_d;
    logic [PW-1:0]     p_q, p_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;
    logic              cb_q, cb_d;
    logic [15:0]       ucnt_q, ucnt_d;
    logic              fco1_q, fco1_d;
    logic              fco2_q, fco2_d;
    logic              fs_q, fs_d;

    adc_mode_e         mode_e;
    logic              boundary;
    logic              shift;
    logic              use_din;
    logic [WIDTH-1:0]  common_word;

    // Frame boundary and sample handshake; ready is held low during reset
    always_comb begin
        mode_e    = adc_mode_e'(mode);
        boundary  = (state_q == ST_IDLE) ? en : (p_q == P_LAST);
        din_ready = rst_n && boundary && en && (mode_e == MODE_DIN);
    end

    // Next state, pattern generators and frame-clock outputs
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        ramp_d      = ramp_q;
        cb_d        = cb_q;
        ucnt_d      = ucnt_q;
        shift       = 1'b0;
        use_din     = 1'b0;
        common_word = '0;
        fco1_d      = 1'b0;
        fco2_d      = 1'b0;
        fs_d        = 1'b0;

        if (boundary) begin
            p_d = '0;
            if (en) begin
                state_d = ST_RUN;
                unique case (mode_e)
                    MODE_DIN: begin
                        if (din_valid) begin
                            use_din = 1'b1;
                        end else begin
                            common_word = MIDSCALE;
                            if (ucnt_q != 16'hFFFF) begin
                                ucnt_d = ucnt_q + 16'd1;
                            end
                        end
                    end
                    MODE_RAMP: begin
                        common_word = WIDTH'(ramp_q);
                        ramp_d      = ramp_q + RAMP_W'(1);
                    end
                    MODE_CHECKER: begin
                        common_word = cb_q ? WIDTH'(CHECKER_B) : WIDTH'(CHECKER_A);
                        cb_d        = ~cb_q;
                    end
                    MODE_MIDSCALE: begin
                        common_word = WIDTH'(FIXED_MIDSCALE);
                    end
                    default: ;
                endcase
            end else begin
                // Lanes load zero so IDLE outputs are quiet; checkerboard restarts
                state_d = ST_IDLE;
                cb_d    = 1'b0;
            end
        end else if (state_q == ST_RUN) begin
            p_d   = p_q + PW'(1);
            shift = 1'b1;
        end

        // Frame clock: high for the first half of the frame, split pair when odd
        if (state_d == ST_RUN) begin
            fs_d = (p_d == '0);
            if (p_d < P_FCO) begin
                fco1_d = 1'b1;
                fco2_d = 1'b1;
            end else if (FCO_MID && (p_d == P_FCO)) begin
                fco1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge dco or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            ramp_q  <= RAMP_INIT;
            cb_q    <= 1'b0;
            ucnt_q  <= '0;
            fco1_q  <= 1'b0;
            fco2_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            ramp_q  <= ramp_d;
            cb_q    <= cb_d;
            ucnt_q  <= ucnt_d;
            fco1_q  <= fco1_d;
            fco2_q  <= fco2_d;
            fs_q    <= fs_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] lane_word;

        assign lane_word = en ? ((use_din ? din[i*WIDTH +: WIDTH] : common_word)
                                 ^ {WIDTH{inv_mask[i]}})
                              : '0;

        adc_lane_shift #(
            .WIDTH (WIDTH)
        ) u_shift (
            .clk     (dco),
            .rst_n   (rst_n),
            .load_i  (boundary),
            .shift_i (shift),
            .word_i  (lane_word),
            .q1_o    (dq1[i]),
            .q2_o    (dq2[i])
        );
    end

    assign fco_q1        = fco1_q;
    assign fco_q2        = fco2_q;
    assign frame_start   = fs_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_adc_lane_serializer.sv
// Self-checking bench for adc_lane_serializer (8 lanes x 14 bits).
module tb_adc_lane_serializer;

    localparam int L = 8;
    localparam int W = 14;
    localparam int H = W / 2;

    logic           dco = 1'b0;
    logic           rst_n;
    logic           en;
    logic [1:0]     mode;
    logic [L-1:0]   inv_mask;
    logic [L*W-1:0] din;
    logic           din_valid;
    logic           din_ready;
    logic [L-1:0]   dq1;
    logic [L-1:0]   dq2;
    logic           fco_q1;
    logic           fco_q2;
    logic           frame_start;
    logic [15:0]    underflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    adc_lane_serializer #(
        .LANES     (L),
        .WIDTH     (W),
        .RAMP_INIT (14'h3FFE)
    ) dut (
        .dco           (dco),
        .rst_n         (rst_n),
        .en            (en),
        .mode          (mode),
        .inv_mask      (inv_mask),
        .din           (din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .dq1           (dq1),
        .dq2           (dq2),
        .fco_q1        (fco_q1),
        .fco_q2        (fco_q2),
        .frame_start   (frame_start),
        .underflow_cnt (underflow_cnt)
    );

    always #5 dco = ~dco;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // m_pos: -1 when idle, else index of the pair being shown this cycle
    int                   m_pos  = -1;
    logic [L-1:0][W-1:0]  m_word = '0;
    logic [13:0]          m_ramp = 14'h3FFE;
    bit                   m_cb   = 1'b0;
    int                   m_ucnt = 0;

    always @(posedge dco or negedge rst_n) begin : model
        bit bnd;
        logic [W-1:0] src;
        if (!rst_n) begin
            m_pos = -1; m_word = '0; m_ramp = 14'h3FFE; m_cb = 1'b0; m_ucnt = 0;
        end else begin
            bnd = (m_pos < 0 && en) || (m_pos == H - 1);
            if (bnd && en) begin
                for (int i = 0; i < L; i++) begin
                    case (mode)
                        2'd0:    src = din_valid ? din[i*W +: W] : 14'(2 ** (W - 1));
                        2'd1:    src = m_ramp;
                        2'd2:    src = m_cb ? 14'h1555 : 14'h2AAA;
                        default: src = 14'h2000;
                    endcase
                    m_word[i] = src ^ {W{inv_mask[i]}};
                end
                if (mode == 2'd0 && !din_valid && m_ucnt < 65535) m_ucnt++;
                if (mode == 2'd1) m_ramp = 14'((32'(m_ramp) + 1) % 16384);
                if (mode == 2'd2) m_cb = !m_cb;
                m_pos = 0;
            end else if (bnd) begin
                m_pos = -1; m_word = '0; m_cb = 1'b0;
            end else if (m_pos >= 0) begin
                m_pos++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge dco) begin : compare
        logic [L-1:0] e1, e2;
        logic ef1, ef2, efs, erdy;
        if (started) begin
            e1 = '0; e2 = '0; ef1 = 1'b0; ef2 = 1'b0; efs = 1'b0;
            if (m_pos >= 0) begin
                for (int i = 0; i < L; i++) begin
                    e1[i] = m_word[i][W - 1 - 2 * m_pos];
                    e2[i] = m_word[i][W - 2 - 2 * m_pos];
                end
                efs = (m_pos == 0);
                if (m_pos < W / 4) begin
                    ef1 = 1'b1; ef2 = 1'b1;
                end else if (m_pos == W / 4 && (H % 2) == 1) begin
                    ef1 = 1'b1;
                end
            end
            erdy = rst_n && ((m_pos < 0 && en) || m_pos == H - 1) && en && (mode == 2'd0);
            chk("dq1", 128'(dq1), 128'(e1));
            chk("dq2", 128'(dq2), 128'(e2));
            chk("fco", 128'({fco_q1, fco_q2}), 128'({ef1, ef2}));
            chk("frame_start", 128'(frame_start), 128'(efs));
            chk("din_ready", 128'(din_ready), 128'(erdy));
            chk("underflow_cnt", 128'(underflow_cnt), 128'(m_ucnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_din(input logic [W-1:0] base, input logic [W-1:0] step);
        for (int i = 0; i < L; i++) din[i*W +: W] = base + 14'(i) * step;
    endtask

    // Capture one whole frame from all lanes; optionally change en/mode after pair hook_at
    task automatic grab(input int hook_at, input logic hook_en, input logic [1:0] hook_mode,
                        output logic [L-1:0][W-1:0] words, output logic [13:0] fseq,
                        output int waited);
        waited = 0; words = '0; fseq = '0;
        @(negedge dco);
        while (!frame_start && waited < 40) begin
            @(negedge dco);
            waited++;
        end
        if (!frame_start) chk("frame_start_timeout", 128'(frame_start), 128'(1));
        for (int k = 0; k < H; k++) begin
            if (k != 0) @(negedge dco);
            for (int i = 0; i < L; i++) words[i] = {words[i][W-3:0], dq1[i], dq2[i]};
            fseq = {fseq[11:0], fco_q1, fco_q2};
            if (k == hook_at) begin
                #1;
                en   = hook_en;
                mode = hook_mode;
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [L-1:0][W-1:0] w;
        logic [L*W-1:0]      saved;
        logic [13:0]         f;
        int                  wt;

        rst_n = 1'b0; en = 1'b1; mode = 2'd0; inv_mask = '0; din_valid = 1'b1;
        din = '0;
        set_din(14'h1234, 14'h0111);
        repeat (3) @(posedge dco);
        #2 started = 1'b1;

        // Reset state
        @(negedge dco);
        chk("rst_dq1", 128'(dq1), 128'(0));
        chk("rst_fco", 128'({fco_q1, fco_q2}), 128'(0));
        chk("rst_ucnt", 128'(underflow_cnt), 128'(0));
        chk("rst_ready", 128'(din_ready), 128'(0));

        // Release with en=1, lane a = 0x1234: idle pair 00, then 01,00,10,00,11,01,00
        @(posedge dco);
        #2 rst_n = 1'b1;
        @(negedge dco);
        chk("rel_idle_pair", 128'({dq1[0], dq2[0]}), 128'(0));
        chk("rel_ready", 128'(din_ready), 128'(1));
        grab(-1, 1'b1, 2'd0, w, f, wt);
        chk("rel_latency", 128'(wt), 128'(0));
        chk("rel_lane_a", 128'(w[0]), 128'(14'h1234));
        chk("rel_fco_seq", 128'(f), 128'(14'b11_11_11_10_00_00_00));

        // Three underflow frames
        #1 din_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            grab(-1, 1'b1, 2'd0, w, f, wt);
            chk("uf_lanes", 128'(w), 128'({L{14'h2000}}));
        end
        chk("uf_count", 128'(underflow_cnt), 128'(3));

        // Ramp across the wrap
        #1 mode = 2'd1;
        grab(-1, 1'b1, 2'd1, w, f, wt);
        chk("ramp_0", 128'(w), 128'({L{14'h3FFE}}));
        grab(-1, 1'b1, 2'd1, w, f, wt);
        chk("ramp_1", 128'(w), 128'({L{14'h3FFF}}));
        grab(-1, 1'b1, 2'd1, w, f, wt);
        chk("ramp_2", 128'(w), 128'({L{14'h0000}}));
        chk("ramp_ucnt_hold", 128'(underflow_cnt), 128'(3));

        // Inversion of lane a only
        #1 mode = 2'd0; din = '0; din_valid = 1'b1; inv_mask = 8'h01;
        grab(-1, 1'b1, 2'd0, w, f, wt);
        chk("inv_lanes", 128'(w), 128'({{(L-1){14'h0000}}, 14'h3FFF}));

        // Fixed midscale with lane a still inverted
        #1 mode = 2'd3;
        grab(-1, 1'b1, 2'd3, w, f, wt);
        chk("mid_lanes", 128'(w), 128'({{(L-1){14'h2000}}, 14'h1FFF}));

        // en dropped at p=2: frame completes, then quiet IDLE
        #1 mode = 2'd0; inv_mask = '0; set_din(14'h0ABC, 14'h0505); saved = din;
        grab(2, 1'b0, 2'd0, w, f, wt);
        chk("drop_frame", 128'(w), 128'(saved));
        chk("drop_fco_seq", 128'(f), 128'(14'b11_11_11_10_00_00_00));
        for (int n = 0; n < 3; n++) begin
            @(negedge dco);
            chk("idle_dq", 128'({dq1, dq2}), 128'(0));
            chk("idle_fco_fs", 128'({fco_q1, fco_q2, frame_start}), 128'(0));
            chk("idle_ready", 128'(din_ready), 128'(0));
        end

        // Mode 0 -> 2 at p=3: current frame stays din, then 2AAA, 1555
        #1 en = 1'b1; set_din(14'h3C01, 14'h0123); saved = din;
        grab(3, 1'b1, 2'd2, w, f, wt);
        chk("sw_din_frame", 128'(w), 128'(saved));
        grab(-1, 1'b1, 2'd2, w, f, wt);
        chk("sw_cb_a", 128'(w), 128'({L{14'h2AAA}}));
        grab(6, 1'b0, 2'd2, w, f, wt);
        chk("sw_cb_b", 128'(w), 128'({L{14'h1555}}));
        @(negedge dco);
        chk("cb_idle_dq", 128'({dq1, dq2}), 128'(0));
        #1 en = 1'b1;
        grab(-1, 1'b1, 2'd2, w, f, wt);
        chk("cb_restart_latency", 128'(wt), 128'(0));
        chk("cb_restart", 128'(w), 128'({L{14'h2AAA}}));

        // Reset mid-frame, then restart under the en rule
        #1 mode = 2'd1;
        @(negedge dco);
        chk("pre_rst_fs", 128'(frame_start), 128'(1));
        repeat (3) @(negedge dco);
        #1 rst_n = 1'b0;
        @(negedge dco);
        chk("abort_dq", 128'({dq1, dq2}), 128'(0));
        chk("abort_fco_fs", 128'({fco_q1, fco_q2, frame_start}), 128'(0));
        chk("abort_ucnt", 128'(underflow_cnt), 128'(0));
        #1 en = 1'b0;
        @(posedge dco);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge dco);
            chk("post_rst_idle", 128'({dq1, frame_start}), 128'(0));
        end
        #1 en = 1'b1;
        grab(-1, 1'b1, 2'd1, w, f, wt);
        chk("post_rst_latency", 128'(wt), 128'(0));
        chk("post_rst_ramp0", 128'(w), 128'({L{14'h3FFE}}));
        grab(-1, 1'b1, 2'd1, w, f, wt);
        chk("post_rst_ramp1", 128'(w), 128'({L{14'h3FFF}}));

        #1 en = 1'b0;
        repeat (12) @(negedge dco);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
